hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side companion to the execute-stage forwarding logic: tracks in-flight register writes from issue (decode->execute)
//  to retirement (writeback), and stalls decode when an operand cannot be forwarded in time (load-use, or any pending write
//  when forwarding is disabled). Sits beside decode; stall_o gates issue_v_i and inserts a bubble into execute.
// PARAMETERS
//  NUM_REGS    32  architectural registers; x0 never tracked
//  LOAD_LAT    1   cycles after load issue during which its rd is not forwardable (1..3)
//  FORWARD_EN  1   1: stall only on load shadow; 0: stall on any pending write (full interlock)
// PORTS
//  clk_i              in   1               clock, all state on rising edge
//  rst_n_i            in   1               synchronous reset, active low
//  issue_v_i          in   1               instruction enters execute this cycle (already qualified by ~stall_o)
//  issue_rd_w_v_i     in   1               issuing instruction writes rd
//  issue_rd_i         in   rvga_reg        issuing destination register
//  issue_load_i       in   1               issuing instruction is a load
//  retire_v_i         in   1               writeback commits this cycle
//  retire_rd_w_v_i    in   1               retiring instruction writes rd
//  retire_rd_i        in   rvga_reg        retiring destination register
//  flush_i            in   1               squash all in-flight state
//  decode_rs1_v_i     in   1               decode reads rs1
//  decode_rs1_i       in   rvga_reg        decode rs1
//  decode_rs2_v_i     in   1               decode reads rs2
//  decode_rs2_i       in   rvga_reg        decode rs2
//  stall_o            out  1               hold decode, bubble into execute
//  pending_mask_o     out  NUM_REGS        bit r set when pend_cnt[r] != 0; bit 0 always 0
//  err_o              out  1               sticky counter over/underflow
// BEHAVIOUR
//  State per reg r (1..NUM_REGS-1): pend_cnt[r] 2b (0..3), shadow[r] 2b (0..LOAD_LAT); err sticky bit.
//  Reset (rst_n_i=0 at edge): all pend_cnt=0, shadow=0, err=0; stall_o=0, pending_mask_o=0, err_o=0 while rst_n_i low.
//  Issue counts iff issue_v_i & issue_rd_w_v_i & issue_rd_i!=0; retire counts iff retire_v_i & retire_rd_w_v_i & retire_rd_i!=0.
//  pend_cnt[r] next: +1 on issue to r, -1 on retire of r, unchanged if both same cycle.
//  Overflow (issue only, cnt==3): cnt stays 3, err<=1. Underflow (retire only, cnt==0): cnt stays 0, err<=1.
//  shadow[r]: loaded with LOAD_LAT on counted load issue to r; else decrements toward 0 each cycle.
//  Non-load issue to r clears shadow[r] (younger writer supersedes).
//  flush_i (priority over issue/retire same cycle): all pend_cnt=0, all shadow=0; err unchanged.
//  dep(rs,v) = v & rs!=0 & (FORWARD_EN ? shadow[rs]!=0 : pend_cnt[rs]!=0).
//  stall_o = dep(rs1) | dep(rs2); combinational from registered state + decode inputs, 0 in reset.
//  Same-cycle issue is not visible to stall_o until next cycle (issuing instr is the one in decode last cycle).
//  Latency: load issued cycle N -> dependent decode stalls cycles N+1..N+LOAD_LAT, proceeds N+LOAD_LAT+1.
//  pending_mask_o and err_o are registered-state views, updated one cycle after the causing event.
//  Reset mid-operation: all state cleared next edge regardless of issue/retire/flush.
// TESTING
//  Reset: hold rst_n_i=0 2 cycles with issue traffic -> stall_o=0, pending_mask_o=0, err_o=0 after release.
//  Load-use: issue lw x5 cycle 0, decode rs1=x5 cycle 1 -> stall_o=1 cycle 1 only (LOAD_LAT=1), 0 cycle 2.
//  ALU op: issue add x5 then decode rs2=x5 -> stall_o=0 (FORWARD_EN=1); FORWARD_EN=0 -> stall until x5 retires.
//  x0: issue lw x0, decode rs1=x0 -> stall_o=0, pending_mask_o[0]=0.
//  Counters: 3 issues to x7 -> mask[7]=1; simultaneous issue+retire x7 -> cnt 3; 4th issue -> err_o=1; 3 retires -> mask[7]=0.
//  Flush: issue lw x9, flush_i next cycle with retire x9 -> all cnt 0, stall_o=0, err_o unchanged (0).

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: issue, retire and flush events from the pipeline,
// decode operand queries, and the scoreboard's stall/status outputs.
//   master : pipeline side (drives issue/retire/flush/decode, reads status)
//   slave  : scoreboard side
interface hazard_scoreboard_if #(
   parameter int unsigned NUM_REGS = 32
);
   localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                issue_v_i;
   logic                issue_rd_w_v_i;
   logic [RW-1:0]       issue_rd_i;
   logic                issue_load_i;
   logic                retire_v_i;
   logic                retire_rd_w_v_i;
   logic [RW-1:0]       retire_rd_i;
   logic                flush_i;
   logic                decode_rs1_v_i;
   logic [RW-1:0]       decode_rs1_i;
   logic                decode_rs2_v_i;
   logic [RW-1:0]       decode_rs2_i;
   logic                stall_o;
   logic [NUM_REGS-1:0] pending_mask_o;
   logic                err_o;

   modport master (
      output issue_v_i, issue_rd_w_v_i, issue_rd_i, issue_load_i,
      output retire_v_i, retire_rd_w_v_i, retire_rd_i, flush_i,
      output decode_rs1_v_i, decode_rs1_i, decode_rs2_v_i, decode_rs2_i,
      input  stall_o, pending_mask_o, err_o
   );

   modport slave (
      input  issue_v_i, issue_rd_w_v_i, issue_rd_i, issue_load_i,
      input  retire_v_i, retire_rd_w_v_i, retire_rd_i, flush_i,
      input  decode_rs1_v_i, decode_rs1_i, decode_rs2_v_i, decode_rs2_i,
      output stall_o, pending_mask_o, err_o
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes from issue to
// retirement and stalls decode when an operand cannot be forwarded in time
// (load shadow, or any pending write when forwarding is disabled).
// Ports:
//   clk_i    clock, all state on rising edge
//   rst_n_i  synchronous reset, active low
//   bus      hazard_scoreboard_if.slave (issue/retire/flush/decode inputs;
//            stall_o, pending_mask_o, err_o outputs)
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned LOAD_LAT   = 1,
   parameter bit          FORWARD_EN = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   hazard_scoreboard_if.slave  bus
);
   localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [1:0] cnt_q    [NUM_REGS];
   logic [1:0] cnt_d    [NUM_REGS];
   logic [1:0] shadow_q [NUM_REGS];
   logic [1:0] shadow_d [NUM_REGS];
   logic       err_q, err_d;

   logic       issue_cnt, retire_cnt;
   logic       inc, dec;
   logic       dep1, dep2;

   assign issue_cnt  = bus.issue_v_i & bus.issue_rd_w_v_i & (bus.issue_rd_i != '0);
   assign retire_cnt = bus.retire_v_i & bus.retire_rd_w_v_i & (bus.retire_rd_i != '0);

   // Next-state for counters, load shadows and the sticky error bit.
   always_comb begin
      err_d       = err_q;
      inc         = 1'b0;
      dec         = 1'b0;
      cnt_d[0]    = '0;
      shadow_d[0] = '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         cnt_d[r]    = cnt_q[r];
         shadow_d[r] = shadow_q[r];
         inc = issue_cnt  && (bus.issue_rd_i  == RW'(r));
         dec = retire_cnt && (bus.retire_rd_i == RW'(r));

         // Simultaneous issue and retire of the same register cancel out.
         if (inc && !dec) begin
            if (cnt_q[r] == 2'd3) err_d = 1'b1;
            else                  cnt_d[r] = cnt_q[r] + 2'd1;
         end else if (dec && !inc) begin
            if (cnt_q[r] == 2'd0) err_d = 1'b1;
            else                  cnt_d[r] = cnt_q[r] - 2'd1;
         end

         // A younger non-load writer supersedes an outstanding load shadow.
         if (inc)                       shadow_d[r] = bus.issue_load_i ? 2'(LOAD_LAT) : 2'd0;
         else if (shadow_q[r] != 2'd0)  shadow_d[r] = shadow_q[r] - 2'd1;
      end

      // Flush overrides same-cycle issue/retire, including their error effects.
      if (bus.flush_i) begin
         err_d = err_q;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r]    = '0;
            shadow_d[r] = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r]    <= '0;
            shadow_q[r] <= '0;
         end
      end else begin
         err_q <= err_d;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r]    <= cnt_d[r];
            shadow_q[r] <= shadow_d[r];
         end
      end
   end

   // Stall looks only at registered state, so a same-cycle issue is not seen.
   always_comb begin
      dep1 = bus.decode_rs1_v_i && (bus.decode_rs1_i != '0) &&
             (FORWARD_EN ? (shadow_q[bus.decode_rs1_i] != 2'd0) : (cnt_q[bus.decode_rs1_i] != 2'd0));
      dep2 = bus.decode_rs2_v_i && (bus.decode_rs2_i != '0) &&
             (FORWARD_EN ? (shadow_q[bus.decode_rs2_i] != 2'd0) : (cnt_q[bus.decode_rs2_i] != 2'd0));
      bus.stall_o = rst_n_i & (dep1 | dep2);
      bus.err_o   = rst_n_i & err_q;
      bus.pending_mask_o = '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         bus.pending_mask_o[r] = rst_n_i && (cnt_q[r] != 2'd0);
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.NUM_REGS(32)) if0 ();
   hazard_scoreboard_if #(.NUM_REGS(32)) if1 ();
   hazard_scoreboard_if #(.NUM_REGS(32)) if2 ();

   // dut0: LOAD_LAT=1 forwarding; dut1: full interlock; dut2: LOAD_LAT=3 forwarding
   hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .FORWARD_EN(1'b1)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(if0));
   hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .FORWARD_EN(1'b0)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1));
   hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(3), .FORWARD_EN(1'b1)) dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2));

   assign if1.issue_v_i       = if0.issue_v_i;
   assign if1.issue_rd_w_v_i  = if0.issue_rd_w_v_i;
   assign if1.issue_rd_i      = if0.issue_rd_i;
   assign if1.issue_load_i    = if0.issue_load_i;
   assign if1.retire_v_i      = if0.retire_v_i;
   assign if1.retire_rd_w_v_i = if0.retire_rd_w_v_i;
   assign if1.retire_rd_i     = if0.retire_rd_i;
   assign if1.flush_i         = if0.flush_i;
   assign if1.decode_rs1_v_i  = if0.decode_rs1_v_i;
   assign if1.decode_rs1_i    = if0.decode_rs1_i;
   assign if1.decode_rs2_v_i  = if0.decode_rs2_v_i;
   assign if1.decode_rs2_i    = if0.decode_rs2_i;
   assign if2.issue_v_i       = if0.issue_v_i;
   assign if2.issue_rd_w_v_i  = if0.issue_rd_w_v_i;
   assign if2.issue_rd_i      = if0.issue_rd_i;
   assign if2.issue_load_i    = if0.issue_load_i;
   assign if2.retire_v_i      = if0.retire_v_i;
   assign if2.retire_rd_w_v_i = if0.retire_rd_w_v_i;
   assign if2.retire_rd_i     = if0.retire_rd_i;
   assign if2.flush_i         = if0.flush_i;
   assign if2.decode_rs1_v_i  = if0.decode_rs1_v_i;
   assign if2.decode_rs1_i    = if0.decode_rs1_i;
   assign if2.decode_rs2_v_i  = if0.decode_rs2_v_i;
   assign if2.decode_rs2_i    = if0.decode_rs2_i;

   typedef struct {
      logic        rst_n;
      logic        iv, iw, il;
      logic [4:0]  ird;
      logic        rv, rw;
      logic [4:0]  rrd;
      logic        fl;
      logic        s1v;
      logic [4:0]  s1;
      logic        s2v;
      logic [4:0]  s2;
      logic [2:0]  st;     // expected stall {dut2, dut1, dut0}
      logic [31:0] mask;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, bit iv, bit iw, bit il, int ird, bit rv, bit rw, int rrd, bit fl,
                               bit s1v, int s1, bit s2v, int s2, logic [2:0] st, logic [31:0] mask, bit err);
      vec_t v;
      v.rst_n = r; v.iv = iv; v.iw = iw; v.il = il; v.ird = 5'(ird);
      v.rv = rv; v.rw = rw; v.rrd = 5'(rrd); v.fl = fl;
      v.s1v = s1v; v.s1 = 5'(s1); v.s2v = s2v; v.s2 = 5'(s2);
      v.st = st; v.mask = mask; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n              = v.rst_n;
      if0.issue_v_i       = v.iv;
      if0.issue_rd_w_v_i  = v.iw;
      if0.issue_load_i    = v.il;
      if0.issue_rd_i      = v.ird;
      if0.retire_v_i      = v.rv;
      if0.retire_rd_w_v_i = v.rw;
      if0.retire_rd_i     = v.rrd;
      if0.flush_i         = v.fl;
      if0.decode_rs1_v_i  = v.s1v;
      if0.decode_rs1_i    = v.s1;
      if0.decode_rs2_v_i  = v.s2v;
      if0.decode_rs2_i    = v.s2;
   endtask

   task automatic check_all(input int idx, input logic [2:0] st, input logic [31:0] mask, input logic err);
      chk("stall_fwd_lat1",  idx, {31'd0, if0.stall_o}, {31'd0, st[0]});
      chk("stall_interlock", idx, {31'd0, if1.stall_o}, {31'd0, st[1]});
      chk("stall_fwd_lat3",  idx, {31'd0, if2.stall_o}, {31'd0, st[2]});
      chk("pending_mask",    idx, if0.pending_mask_o, mask);
      chk("pending_mask_il", idx, if1.pending_mask_o, mask);
      chk("err",             idx, {31'd0, if0.err_o}, {31'd0, err});
   endtask

   initial begin
      vec_t v;
      // Each row: inputs applied for one cycle; expectations are the outputs
      // seen in that cycle, before the rising edge that consumes the inputs.
      //           rst iv iw il ird rv rw rrd fl s1v s1 s2v s2  stall   mask     err
      vecs.push_back(mk(0, 1,1,1, 5,  0,0,0,  0, 1,5,  0,0,  3'b000, 32'h0,   0)); // 0 reset with traffic
      vecs.push_back(mk(0, 1,1,1, 5,  0,0,0,  0, 1,5,  0,0,  3'b000, 32'h0,   0));
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,5,  0,0,  3'b000, 32'h0,   0)); // 2 after release
      vecs.push_back(mk(1, 1,1,1, 5,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 3 lw x5
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,5,  0,0,  3'b111, 32'h20,  0)); // 4 load-use
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,5,  0,0,  3'b110, 32'h20,  0));
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,5,  0,0,  3'b110, 32'h20,  0));
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,5,  0, 1,5,  0,0,  3'b010, 32'h20,  0)); // 7 retire x5
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 0,0,  1,5,  3'b000, 32'h0,   0));
      vecs.push_back(mk(1, 1,1,0, 5,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 9 add x5
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 0,0,  1,5,  3'b010, 32'h20,  0));
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,5,  0, 0,0,  1,5,  3'b010, 32'h20,  0));
      vecs.push_back(mk(1, 1,0,1, 8,  0,0,0,  0, 0,0,  1,5,  3'b000, 32'h0,   0)); // 12 issue without rd write
      vecs.push_back(mk(1, 1,1,1, 6,  0,0,0,  0, 1,8,  0,0,  3'b000, 32'h0,   0)); // 13 lw x6
      vecs.push_back(mk(1, 1,1,0, 6,  0,0,0,  0, 1,6,  0,0,  3'b111, 32'h40,  0)); // 14 add x6 supersedes
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,6,  0, 1,6,  0,0,  3'b010, 32'h40,  0));
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,6,  0, 1,6,  1,0,  3'b010, 32'h40,  0));
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,6,  0,0,  3'b000, 32'h0,   0));
      vecs.push_back(mk(1, 1,1,1, 0,  0,0,0,  0, 1,0,  0,0,  3'b000, 32'h0,   0)); // 18 lw x0
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,0,  0, 1,0,  1,0,  3'b000, 32'h0,   0)); // 19 retire x0 ignored
      vecs.push_back(mk(1, 0,0,0, 0,  1,0,6,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 20 retire without rd write
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0));
      vecs.push_back(mk(1, 1,1,0, 7,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 22 x7 cnt 1
      vecs.push_back(mk(1, 1,1,0, 7,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h80,  0)); //    cnt 2
      vecs.push_back(mk(1, 1,1,0, 7,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h80,  0)); //    cnt 3
      vecs.push_back(mk(1, 1,1,0, 7,  1,1,7,  0, 0,0,  0,0,  3'b000, 32'h80,  0)); // 25 issue+retire
      vecs.push_back(mk(1, 1,1,0, 7,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h80,  0)); // 26 overflow
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,7,  0, 0,0,  0,0,  3'b000, 32'h80,  1));
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,7,  0, 0,0,  0,0,  3'b000, 32'h80,  1));
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,7,  0, 0,0,  0,0,  3'b000, 32'h80,  1));
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,7,  0,0,  3'b000, 32'h0,   1)); // 30 x7 drained
      vecs.push_back(mk(0, 1,1,0, 7,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 31 reset clears err
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0));
      vecs.push_back(mk(1, 1,1,1, 9,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 33 lw x9
      vecs.push_back(mk(1, 1,1,0,10,  1,1,9,  1, 1,9,  0,0,  3'b111, 32'h200, 0)); // 34 flush wins
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,9,  1,10, 3'b000, 32'h0,   0));
      vecs.push_back(mk(1, 0,0,0, 0,  1,1,3,  0, 0,0,  0,0,  3'b000, 32'h0,   0)); // 36 underflow
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  1, 0,0,  0,0,  3'b000, 32'h0,   1)); // 37 flush keeps err
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   1));
      vecs.push_back(mk(1, 1,1,0, 4,  0,0,0,  0, 0,0,  0,0,  3'b000, 32'h0,   1)); // 39 add x4
      vecs.push_back(mk(0, 1,1,0, 4,  1,1,4,  0, 1,4,  0,0,  3'b000, 32'h0,   0)); // 40 mid-op reset
      vecs.push_back(mk(1, 0,0,0, 0,  0,0,0,  0, 1,4,  0,0,  3'b000, 32'h0,   0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check_all(i, vecs[i].st, vecs[i].mask, vecs[i].err);
      end

      // Occupy every register x1..x31 with one ALU write, then drain them.
      for (int r = 1; r < 32; r++) begin
         @(negedge clk);
         v = mk(1, 1,1,0, r, 0,0,0, 0, 0,0, 0,0, 3'b000, 32'h0, 0);
         drive(v);
      end
      @(negedge clk);
      v = mk(1, 0,0,0, 0, 0,0,0, 0, 1,31, 1,1, 3'b000, 32'h0, 0);
      drive(v);
      #1;
      check_all(100, 3'b010, 32'hFFFF_FFFE, 1'b0);
      for (int r = 1; r < 32; r++) begin
         @(negedge clk);
         v = mk(1, 0,0,0, 0, 1,1,r, 0, 0,0, 0,0, 3'b000, 32'h0, 0);
         drive(v);
      end
      @(negedge clk);
      v = mk(1, 0,0,0, 0, 0,0,0, 0, 1,31, 1,1, 3'b000, 32'h0, 0);
      drive(v);
      #1;
      check_all(101, 3'b000, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
